// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer for two cores sharing one single-port synchronous RAM.
// A core may hold priority for up to MAX_BURST back-to-back grants via its lock input.
module ram_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core0_req,
    input  logic              core0_we,
    input  logic [ADDR_W-1:0] core0_addr,
    input  logic [DATA_W-1:0] core0_wdata,
    input  logic              core0_lock,
    output logic              core0_gnt,
    output logic              core0_rvalid,
    output logic [DATA_W-1:0] core0_rdata,
    input  logic              core1_req,
    input  logic              core1_we,
    input  logic [ADDR_W-1:0] core1_addr,
    input  logic [DATA_W-1:0] core1_wdata,
    input  logic              core1_lock,
    output logic              core1_gnt,
    output logic              core1_rvalid,
    output logic [DATA_W-1:0] core1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    // state     | meaning
    // IDLE      | sample requests, grant a winner and launch its RAM access
    // ACCESS    | RAM samples the access on the closing edge
    // READ_WAIT | RAM read data is valid; capture it for the last winner
    typedef enum logic [1:0] {IDLE, ACCESS, READ_WAIT} state_t;

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t            state;
    logic              last;
    logic              locked;
    logic [CNT_W-1:0]  burst_cnt;

    logic [1:0]        req;
    logic              win;
    logic [CNT_W-1:0]  cnt_next;
    logic              lock_next;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        req      = {core1_req, core0_req};
        win      = 1'b0;
        cnt_next = CNT_W'(1);
        if (locked && req[last]) begin
            win      = last;
            cnt_next = burst_cnt + CNT_W'(1);
        end else if (&req) begin
            win = ~last;
        end else begin
            win = req[1];
        end
        sel_we    = win ? core1_we    : core0_we;
        sel_addr  = win ? core1_addr  : core0_addr;
        sel_wdata = win ? core1_wdata : core0_wdata;
        // locking expires once the burst reaches its cap, so the other core gets the next tie
        lock_next = (win ? core1_lock : core0_lock) && (int'(cnt_next) < MAX_BURST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last         <= 1'b1;
            locked       <= 1'b0;
            burst_cnt    <= '0;
            core0_gnt    <= 1'b0;
            core1_gnt    <= 1'b0;
            core0_rvalid <= 1'b0;
            core1_rvalid <= 1'b0;
            core0_rdata  <= '0;
            core1_rdata  <= '0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
        end else begin
            core0_gnt    <= 1'b0;
            core1_gnt    <= 1'b0;
            core0_rvalid <= 1'b0;
            core1_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        core0_gnt <= ~win;
                        core1_gnt <= win;
                        ram_en    <= 1'b1;
                        ram_we    <= sel_we;
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_wdata;
                        last      <= win;
                        burst_cnt <= cnt_next;
                        locked    <= lock_next;
                        state     <= ACCESS;
                    end else begin
                        locked <= 1'b0;
                        ram_en <= 1'b0;
                        ram_we <= 1'b0;
                    end
                end
                ACCESS: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    state  <= ram_we ? IDLE : READ_WAIT;
                end
                READ_WAIT: begin
                    if (last) begin
                        core1_rdata  <= ram_rdata;
                        core1_rvalid <= 1'b1;
                    end else begin
                        core0_rdata  <= ram_rdata;
                        core0_rvalid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: queued/random core traffic against a slot-timing reference model,
// plus a MAX_BURST=1 instance that must alternate strictly under permanent locked contention.
module tb_ram_arbiter;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int MB = 4;

    typedef struct {
        int             gap;
        logic           we;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic           lock;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, rst_b;
    logic [1:0]    req, we, lock;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2];
    logic          gnt0, gnt1, rv0, rv1, ram_en, ram_we;
    logic [DW-1:0] rd0, rd1, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(rst_n),
        .core0_req(req[0]), .core0_we(we[0]), .core0_addr(addr[0]), .core0_wdata(wdata[0]),
        .core0_lock(lock[0]), .core0_gnt(gnt0), .core0_rvalid(rv0), .core0_rdata(rd0),
        .core1_req(req[1]), .core1_we(we[1]), .core1_addr(addr[1]), .core1_wdata(wdata[1]),
        .core1_lock(lock[1]), .core1_gnt(gnt1), .core1_rvalid(rv1), .core1_rdata(rd1),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    logic          b_g0, b_g1, b_rv0, b_rv1, b_en, b_we;
    logic [DW-1:0] b_rd0, b_rd1, b_wd;
    logic [AW-1:0] b_addr;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(1)) dut_b (
        .clk(clk), .reset(rst_b),
        .core0_req(1'b1), .core0_we(1'b0), .core0_addr(9'h010), .core0_wdata(8'h00),
        .core0_lock(1'b1), .core0_gnt(b_g0), .core0_rvalid(b_rv0), .core0_rdata(b_rd0),
        .core1_req(1'b1), .core1_we(1'b0), .core1_addr(9'h020), .core1_wdata(8'h00),
        .core1_lock(1'b1), .core1_gnt(b_g1), .core1_rvalid(b_rv1), .core1_rdata(b_rd1),
        .ram_en(b_en), .ram_we(b_we), .ram_addr(b_addr), .ram_wdata(b_wd),
        .ram_rdata(8'h3C)
    );

    // RAM macro: never-written locations read back a fixed function of the address
    bit [DW-1:0] ram_mem [512];
    bit          ram_wr  [512];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr] <= ram_wdata;
                ram_wr[ram_addr]  <= 1'b1;
            end else begin
                ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : DW'(ram_addr * 37 + 5);
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int n       = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    // reference model: a grant occupies 2 sample slots for a write, 3 for a read
    bit [DW-1:0]   ref_mem [512];
    bit            ref_wr  [512];
    int            next_sample, m_cnt;
    bit            m_last, m_locked;
    int            rv_due  [2];
    logic [DW-1:0] rv_data [2];
    logic [DW-1:0] exp_rd  [2];
    logic [1:0]    e_gnt, e_rv;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    task automatic model_reset();
        m_last = 1'b1; m_locked = 1'b0; m_cnt = 0; next_sample = 0;
        for (int c = 0; c < 2; c++) begin
            rv_due[c] = -1;
            exp_rd[c] = '0;
        end
    endtask

    task automatic model_step();
        int w;
        e_gnt = '0; e_rv = '0; e_en = 1'b0; e_we = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (rv_due[c] == n) begin
                e_rv[c]   = 1'b1;
                exp_rd[c] = rv_data[c];
                rv_due[c] = -1;
            end
        end
        if (n >= next_sample) begin
            if (req == 2'b00) begin
                m_locked = 1'b0;
            end else begin
                if (m_locked && req[m_last]) begin
                    w = int'(m_last);
                    m_cnt++;
                end else begin
                    w = (req == 2'b11) ? int'(!m_last) : int'(req[1]);
                    m_cnt = 1;
                end
                m_locked = lock[w] && (m_cnt < MB);
                m_last   = w[0];
                e_gnt[w] = 1'b1;
                e_en     = 1'b1;
                e_we     = we[w];
                e_addr   = addr[w];
                e_wdata  = wdata[w];
                if (we[w]) begin
                    ref_mem[addr[w]] = wdata[w];
                    ref_wr[addr[w]]  = 1'b1;
                    next_sample = n + 2;
                end else begin
                    rv_due[w]  = n + 2;
                    rv_data[w] = ref_wr[addr[w]] ? ref_mem[addr[w]] : DW'(addr[w] * 37 + 5);
                    next_sample = n + 3;
                end
            end
        end
    endtask

    op_t q0[$];
    op_t q1[$];
    int  wait_c [2];
    bit  rand_en = 1'b0;
    int  glog[$];

    function automatic op_t mk(int gap, logic w, logic [AW-1:0] a, logic [DW-1:0] d, logic l);
        op_t o;
        o.gap = gap; o.we = w; o.addr = a; o.wdata = d; o.lock = l;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.gap   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        o.we    = 1'($urandom_range(0, 1));
        o.addr  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 511));
        o.wdata = DW'($urandom);
        o.lock  = ($urandom_range(0, 2) == 0);
        return o;
    endfunction

    task automatic drive();
        op_t op;
        bit  got;
        for (int c = 0; c < 2; c++) begin
            if (req[c] && ((c == 0) ? gnt0 : gnt1)) req[c] = 1'b0;
            if (!req[c]) begin
                if (wait_c[c] > 0) begin
                    wait_c[c]--;
                end else begin
                    got = 1'b0;
                    if (c == 0 && q0.size() > 0) begin op = q0.pop_front(); got = 1'b1; end
                    else if (c == 1 && q1.size() > 0) begin op = q1.pop_front(); got = 1'b1; end
                    else if (rand_en) begin op = rand_op(); got = 1'b1; end
                    if (got) begin
                        if (op.gap > 0) begin
                            wait_c[c] = op.gap;
                        end else begin
                            req[c] = 1'b1; we[c] = op.we; addr[c] = op.addr;
                            wdata[c] = op.wdata; lock[c] = op.lock;
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        n++;
        if (rst_n) begin
            model_step();
            check("gnt", 64'({gnt1, gnt0}), 64'(e_gnt));
            check("rvalid", 64'({rv1, rv0}), 64'(e_rv));
            check("rdata0", 64'(rd0), 64'(exp_rd[0]));
            check("rdata1", 64'(rd1), 64'(exp_rd[1]));
            check("ram_en", 64'(ram_en), 64'(e_en));
            check("ram_we", 64'(ram_we), 64'(e_we));
            if (e_en) begin
                check("ram_addr", 64'(ram_addr), 64'(e_addr));
                check("ram_wdata", 64'(ram_wdata), 64'(e_wdata));
            end
            if (gnt0 || gnt1) glog.push_back(int'(gnt1));
        end else begin
            check("reset_outs", 64'({gnt0, gnt1, rv0, rv1, ram_en, ram_we, rd0, rd1, ram_addr, ram_wdata}), 64'(0));
        end
        drive();
    endtask

    function automatic bit drained();
        return q0.size() == 0 && q1.size() == 0 && req == 2'b00 && wait_c[0] == 0 && wait_c[1] == 0;
    endfunction

    task automatic settle();
        for (int i = 0; i < 200 && !drained(); i++) tick();
        check("drain", 64'(drained()), 64'(1));
        repeat (4) tick();
    endtask

    // MAX_BURST=1 instance: locks never hold, so grants alternate 0,1,0,... every 3 cycles
    int b_cyc = 0, b_last = -1, b_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_b) begin
                b_cyc++;
                if (b_g0 || b_g1) begin
                    check("mb1_winner", 64'({b_g1, b_g0}), (b_cnt % 2 == 0) ? 64'(1) : 64'(2));
                    if (b_last >= 0) check("mb1_spacing", 64'(b_cyc - b_last), 64'(3));
                    b_last = b_cyc;
                    b_cnt++;
                end
            end
        end
    end

    initial begin
        int run, maxrun;
        bit seen;
        rst_n = 1'b0; rst_b = 1'b0;
        req = '0; we = '0; lock = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        wait_c[0] = 0; wait_c[1] = 0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1; rst_b = 1'b1;
        model_reset();

        q0.push_back(mk(0, 1'b1, 9'h1F3, 8'hA5, 1'b0));
        q0.push_back(mk(0, 1'b0, 9'h1F3, 8'h00, 1'b0));
        settle();
        check("wr_rd_a5", 64'(rd0), 64'(8'hA5));

        glog.delete();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(mk(0, 1'b0, AW'(i), 8'h00, 1'b0));
            q1.push_back(mk(0, 1'b0, AW'(i + 100), 8'h00, 1'b0));
        end
        settle();
        check("contention_grants", 64'(glog.size()), 64'(12));
        for (int i = 1; i < glog.size(); i++) check("contention_alt", 64'(glog[i] != glog[i-1]), 64'(1));

        glog.delete();
        for (int i = 0; i < 6; i++) q1.push_back(mk(0, 1'b1, AW'(i + 40), DW'(i * 3 + 1), 1'b1));
        for (int i = 0; i < 8; i++) q0.push_back(mk(0, 1'b0, AW'(i + 40), 8'h00, 1'b0));
        settle();
        run = 0; maxrun = 0;
        foreach (glog[i]) begin
            run = (glog[i] == 1) ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        check("burst_run", 64'(maxrun), 64'(MB));

        q0.push_back(mk(0, 1'b1, 9'h0AA, 8'h5A, 1'b1));
        q0.push_back(mk(3, 1'b0, 9'h000, 8'h00, 1'b0));
        q0.push_back(mk(0, 1'b0, 9'h0AA, 8'h00, 1'b1));
        for (int i = 0; i < 4; i++) q1.push_back(mk(0, 1'b0, 9'h0AA, 8'h00, 1'b0));
        settle();

        q0.push_back(mk(0, 1'b0, 9'h1F3, 8'h00, 1'b0));
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = gnt0;
        end
        check("read_gnt_seen", 64'(seen), 64'(1));
        tick();
        rst_n = 1'b0;
        #1;
        check("reset_async", 64'({gnt0, gnt1, rv0, rv1, ram_en, ram_we, rd0, rd1, ram_addr, ram_wdata}), 64'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        model_reset();
        glog.delete();
        q0.push_back(mk(0, 1'b0, 9'h003, 8'h00, 1'b0));
        q1.push_back(mk(0, 1'b0, 9'h004, 8'h00, 1'b0));
        drive();
        settle();
        check("tie_after_reset", (glog.size() > 0) ? 64'(glog[0]) : 64'(1), 64'(0));

        rand_en = 1'b1;
        repeat (1500) tick();
        rand_en = 1'b0;
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
